debounced_edge_pio: RTL and testbench

DEBOUNCED_EDGE_PIO -- requirements
Module: debounced_edge_pio

---
 rtl/debounced_edge_pio_if.sv | 29 ++
 rtl/debounced_edge_pio.sv | 124 ++++++++++++
 tb/tb_debounced_edge_pio.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/debounced_edge_pio_if.sv
// Register bus for debounced_edge_pio.
//   address    : register select (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : registered read data (32 bits), one cycle after address
interface debounced_edge_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/debounced_edge_pio.sv
// Debounced parallel input port with per-channel rise/fall edge capture and
// a level interrupt.
//   clk     : sole clock, rising edge
//   reset   : asynchronous, active-high
//   bus     : register bus (slave side), see debounced_edge_pio_if
//   in_port : raw asynchronous inputs, WIDTH bits
//   irq     : OR of (edge_capture & irq_mask), straight from registers
// Register map: 0 DATA (ro), 1 RAW (ro), 2 IRQ_MASK, 3 EDGE_CAPTURE (w1c),
// 4 RISE_EN, 5 FALL_EN, 6/7 read zero.
module debounced_edge_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    debounced_edge_pio_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which the next increment would reach DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [CNT_W-1:0] count      [WIDTH];
    logic [CNT_W-1:0] count_next [WIDTH];
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] capture_next;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      read_mux;
    logic [31:0]      rdata;
    logic             wr;
    logic             unused_wdata;

    assign wr           = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;
    assign bus.readdata = rdata;

    // Per-channel debounce: count consecutive cycles where sync2 disagrees
    // with stable; accept the new level when the run reaches DEBOUNCE_CYCLES.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < WIDTH; i++) begin
            count_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (count[i] == CNT_LAST) begin
                    stable_next[i] = sync2[i];
                end else begin
                    count_next[i] = count[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise_evt = ~stable & stable_next & rise_en;
    assign fall_evt = stable & ~stable_next & fall_en;

    // A fresh event wins over a same-cycle write-1-to-clear of that bit.
    always_comb begin
        w1c = '0;
        if (wr && bus.address == 3'd3) begin
            w1c = bus.writedata[WIDTH-1:0];
        end
        capture_next = (edge_capture & ~w1c) | rise_evt | fall_evt;
    end

    always_comb begin
        read_mux = '0;
        case (bus.address)
            3'd0:    read_mux[WIDTH-1:0] = stable;
            3'd1:    read_mux[WIDTH-1:0] = sync2;
            3'd2:    read_mux[WIDTH-1:0] = irq_mask;
            3'd3:    read_mux[WIDTH-1:0] = edge_capture;
            3'd4:    read_mux[WIDTH-1:0] = rise_en;
            3'd5:    read_mux[WIDTH-1:0] = fall_en;
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            stable       <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            rise_en      <= '1;
            fall_en      <= '0;
            rdata        <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync1        <= in_port;
            sync2        <= sync1;
            stable       <= stable_next;
            edge_capture <= capture_next;
            rdata        <= read_mux;
            for (int i = 0; i < WIDTH; i++) begin
                count[i] <= count_next[i];
            end
            if (wr) begin
                case (bus.address)
                    3'd2:    irq_mask <= bus.writedata[WIDTH-1:0];
                    3'd4:    rise_en  <= bus.writedata[WIDTH-1:0];
                    3'd5:    fall_en  <= bus.writedata[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_debounced_edge_pio.sv
module tb_debounced_edge_pio;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in_port = '0;
    logic         irq;
    logic         checking = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;

    debounced_edge_pio_if bus ();

    debounced_edge_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // A channel's accepted level becomes v once the last DEB synchronised
    // samples are all v. The synchronised sample is in_port two edges late.
    logic [W-1:0] m_sync1, m_sync2, m_stable, m_cap, m_mask, m_rise, m_fall;
    logic [W-1:0] hist [DEB];
    logic [31:0]  m_rd;
    logic [W-1:0] n_stable, n_ev, n_clr;
    logic [31:0]  n_rd;
    logic         n_wr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_cap = '0;
            m_mask = '0; m_rise = '1; m_fall = '0; m_rd = '0;
            for (int k = 0; k < DEB; k++) hist[k] = '0;
        end else begin
            n_wr = bus.chipselect && !bus.write_n;
            n_rd = 32'd0;
            case (bus.address)
                3'd0: n_rd = {28'd0, m_stable};
                3'd1: n_rd = {28'd0, m_sync2};
                3'd2: n_rd = {28'd0, m_mask};
                3'd3: n_rd = {28'd0, m_cap};
                3'd4: n_rd = {28'd0, m_rise};
                3'd5: n_rd = {28'd0, m_fall};
                default: n_rd = 32'd0;
            endcase
            for (int k = DEB - 1; k > 0; k--) hist[k] = hist[k - 1];
            hist[0] = m_sync2;
            n_stable = m_stable;
            for (int i = 0; i < W; i++) begin
                int ones;
                ones = 0;
                for (int k = 0; k < DEB; k++) ones += int'(hist[k][i]);
                if (ones == DEB) n_stable[i] = 1'b1;
                else if (ones == 0) n_stable[i] = 1'b0;
            end
            n_ev  = (~m_stable & n_stable & m_rise) | (m_stable & ~n_stable & m_fall);
            n_clr = (n_wr && bus.address == 3'd3) ? bus.writedata[W-1:0] : '0;
            m_cap = (m_cap & ~n_clr) | n_ev;
            if (n_wr && bus.address == 3'd2) m_mask = bus.writedata[W-1:0];
            if (n_wr && bus.address == 3'd4) m_rise = bus.writedata[W-1:0];
            if (n_wr && bus.address == 3'd5) m_fall = bus.writedata[W-1:0];
            m_stable = n_stable;
            m_sync2  = m_sync1;
            m_sync1  = in_port;
            m_rd     = n_rd;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            vectors++;
            if (bus.readdata !== m_rd) begin
                miscompares++;
                $display("FAIL readdata @%0t: got %h expected %h", $time, bus.readdata, m_rd);
            end
            vectors++;
            if (irq !== |(m_cap & m_mask)) begin
                miscompares++;
                $display("FAIL irq @%0t: got %b expected %b", $time, irq, |(m_cap & m_mask));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        step();
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'hA5A5_5A5A;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        step();
        d = bus.readdata;
    endtask

    // Idle cycles that sweep the read address so every register is observed.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            bus.address = bus.address + 3'd1;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        #1 reset = 1'b1;
        checking = 1'b1;
        #1;
        check_lit("reset readdata", bus.readdata, 32'h0);
        check_lit("reset irq", {31'd0, irq}, 32'h0);
        step(); step();
        reset = 1'b0;
        read_reg(3'd4, d); check_lit("rise_en reset", d, 32'hF);
        read_reg(3'd5, d); check_lit("fall_en reset", d, 32'h0);

        // Short pulse rejected, long press accepted at edge 6.
        in_port = 4'h1; step(); step(); step();
        in_port = 4'h0; idle(10);
        read_reg(3'd0, d); check_lit("glitch data", d, 32'h0);
        read_reg(3'd3, d); check_lit("glitch capture", d, 32'h0);
        bus.address = 3'd0;
        in_port = 4'h1;
        repeat (5) step();
        check_lit("model stable edge5", {28'd0, m_stable}, 32'h0);
        step();
        check_lit("model stable edge6", {28'd0, m_stable}, 32'h1);
        check_lit("model cap edge6", {28'd0, m_cap}, 32'h1);
        read_reg(3'd0, d); check_lit("press data", d, 32'h1);
        read_reg(3'd3, d); check_lit("press capture", d, 32'h1);

        // Write-1-to-clear, and event priority over a same-edge clear.
        write_reg(3'd3, 32'hF);
        in_port = 4'h0; idle(8);
        in_port = 4'h5; idle(8);
        read_reg(3'd3, d); check_lit("cap 5", d, 32'h5);
        write_reg(3'd3, 32'h1);
        read_reg(3'd3, d); check_lit("w1c bit0", d, 32'h4);
        in_port = 4'h4; idle(8);
        in_port = 4'h5;
        repeat (5) step();
        write_reg(3'd3, 32'h1);
        check_lit("model cap priority", {28'd0, m_cap}, 32'h5);
        read_reg(3'd3, d); check_lit("event beats clear", d, 32'h5);

        // Interrupt mask and clear.
        write_reg(3'd2, 32'h4);
        check_lit("irq set", {31'd0, irq}, 32'h1);
        write_reg(3'd3, 32'h4);
        check_lit("irq cleared", {31'd0, irq}, 32'h0);

        // Fall-only enable on channel 1.
        write_reg(3'd4, 32'h0);
        write_reg(3'd5, 32'h2);
        write_reg(3'd3, 32'hF);
        in_port = 4'h7; idle(8);
        read_reg(3'd3, d); check_lit("no rise capture", d, 32'h0);
        in_port = 4'h5; idle(8);
        read_reg(3'd3, d); check_lit("fall capture", d, 32'h2);

        // Unmapped and read-only addresses.
        in_port = 4'h0; idle(8);
        read_reg(3'd6, d); check_lit("addr6 reads 0", d, 32'h0);
        write_reg(3'd0, 32'hFFFF_FFFF);
        read_reg(3'd0, d); check_lit("data ro", d, 32'h0);
        write_reg(3'd1, 32'hFFFF_FFFF);
        write_reg(3'd6, 32'hFFFF_FFFF);
        write_reg(3'd7, 32'hFFFF_FFFF);
        read_reg(3'd7, d); check_lit("addr7 reads 0", d, 32'h0);
        read_reg(3'd2, d); check_lit("mask kept", d, 32'h4);
        read_reg(3'd4, d); check_lit("rise kept", d, 32'h0);
        read_reg(3'd5, d); check_lit("fall kept", d, 32'h2);

        // All channels rising together.
        write_reg(3'd4, 32'hF);
        write_reg(3'd3, 32'hF);
        in_port = 4'hF; idle(8);
        read_reg(3'd3, d); check_lit("simultaneous", d, 32'hF);

        // Pulses of assorted lengths on channel 1, both edges enabled.
        write_reg(3'd5, 32'hF);
        for (int len = 1; len <= 6; len++) begin
            write_reg(3'd3, 32'hF);
            in_port = 4'hD;
            repeat (len) step();
            in_port = 4'hF;
            idle(8);
        end

        // Reset during an in-progress debounce, inputs held high.
        write_reg(3'd2, 32'hF);
        write_reg(3'd3, 32'hF);
        in_port = 4'h0; step(); step();
        in_port = 4'hF; step();
        reset = 1'b1;
        #1;
        check_lit("mid reset readdata", bus.readdata, 32'h0);
        check_lit("mid reset irq", {31'd0, irq}, 32'h0);
        #1;
        step();
        reset = 1'b0;
        bus.address = 3'd0;
        repeat (5) step();
        check_lit("model post-reset edge5", {28'd0, m_stable}, 32'h0);
        step();
        check_lit("model post-reset edge6", {28'd0, m_stable}, 32'hF);
        check_lit("model post-reset cap", {28'd0, m_cap}, 32'hF);
        read_reg(3'd0, d); check_lit("post-reset data", d, 32'hF);
        read_reg(3'd3, d); check_lit("post-reset capture", d, 32'hF);
        check_lit("post-reset irq", {31'd0, irq}, 32'h0);
        idle(4);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
